// File: rtl/runtime_rom_arbiter_pkg.sv
// Shared constants, requester indices and FSM state type for the runtime ROM arbiter.
package runtime_rom_arbiter_pkg;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned ADDR_WIDTH  = 10;
    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned ROM_LATENCY = 1;

    localparam int unsigned REQ_UI       = 0;
    localparam int unsigned REQ_ATTACK   = 1;
    localparam int unsigned REQ_PLATFORM = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    // Width of an index able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/runtime_rom_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first valid requester after last_grant, wrapping.
module runtime_rom_arbiter_rr_priority_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Search last_grant+1, last_grant+2, ... modulo NUM_REQ; the first hit wins.
    always_comb begin
        found    = 1'b0;
        winner_o = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(last_grant_i) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req_valid_i[cand_idx]) begin
                found    = 1'b1;
                winner_o = cand_idx;
            end
        end
        any_req_o = |req_valid_i;
    end

endmodule

// File: rtl/runtime_rom_arbiter.sv
// Shares one synchronous pattern ROM among the UI, attack and platform runtime readers.
module runtime_rom_arbiter #(
    parameter int unsigned NUM_REQ     = runtime_rom_arbiter_pkg::NUM_REQ,
    parameter int unsigned ADDR_WIDTH  = runtime_rom_arbiter_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = runtime_rom_arbiter_pkg::DATA_WIDTH,
    parameter int unsigned ROM_LATENCY = runtime_rom_arbiter_pkg::ROM_LATENCY
) (
    input  logic                          clk_calculation,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          busy
);
    import runtime_rom_arbiter_pkg::*;

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    // Counter holds ROM_LATENCY down to 0.
    localparam int unsigned CNT_W = idx_width(ROM_LATENCY + 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                    busy_q, busy_d;

    logic [IDX_W-1:0]        winner;
    logic                    any_req;
    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end

    runtime_rom_arbiter_rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    // Next state: grant in IDLE, count down ROM latency in WAIT, then return the word.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    rom_en_d     = 1'b1;
                    rom_addr_d   = addr_arr[winner];
                    req_ready_d  = NUM_REQ'(1) << winner;
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_W'(ROM_LATENCY);
                    state_d      = StWait;
                end
            end
            StWait: begin
                // req_valid is deliberately ignored here, so a holder is never re-granted.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d  = rom_data;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; reset abandons any in-flight read.
    always_ff @(posedge clk_calculation) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_runtime_rom_arbiter.sv
// Scoreboard bench for runtime_rom_arbiter: transaction-level model, decoupled monitor.
module tb_runtime_rom_arbiter;

    localparam int unsigned NR  = 3;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 64;
    localparam int unsigned LAT = 1;

    logic              clk_calculation = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              busy;

    always #5 clk_calculation = ~clk_calculation;

    runtime_rom_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ROM_LATENCY (LAT)
    ) dut (
        .clk_calculation (clk_calculation),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rom_en          (rom_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .busy            (busy)
    );

    // Synchronous ROM with LAT cycles from sampled rom_en to data.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk_calculation) begin
        if (rom_en) pipe[0] <= mem[rom_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_data = pipe[LAT-1];

    typedef struct {
        int          cyc;
        int          idx;
        logic [AW-1:0] addr;
    } grant_t;
    typedef struct {
        int          cyc;
        int          idx;
        logic [DW-1:0] data;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];
    int     glog[$];
    int     gcyc[$];
    int     cyc = 0;
    int     busy_lo = -100;
    int     busy_hi = -100;
    int     rsp1_cnt = 0;
    int     errors = 0;
    int     checks = 0;
    bit     chk_en = 1'b0;
    logic [NR-1:0] outst;
    logic [NR-1:0] auto_rq;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant may start every LAT+2 edges; winner by rotating search.
    initial begin
        int e, w, m_last, m_free;
        grant_t g;
        rsp_t r;
        m_last = NR - 1;
        m_free = 0;
        forever begin
            @(posedge clk_calculation);
            e = cyc;
            cyc++;
            if (reset) begin
                gq.delete();
                rq.delete();
                m_last  = NR - 1;
                m_free  = e + 1;
                busy_lo = -100;
                busy_hi = -100;
            end else if (e >= m_free && req_valid != '0) begin
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (w < 0 && req_valid[c]) w = c;
                end
                g.cyc  = e + 1;
                g.idx  = w;
                g.addr = req_addr[w*AW +: AW];
                gq.push_back(g);
                r.cyc  = e + LAT + 2;
                r.idx  = w;
                r.data = mem[g.addr];
                rq.push_back(r);
                busy_lo = e + 1;
                busy_hi = e + LAT + 1;
                m_last  = w;
                m_free  = e + LAT + 2;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or a response.
    initial begin
        grant_t g;
        rsp_t r;
        int idx;
        forever begin
            @(negedge clk_calculation);
            if (chk_en) begin
                chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
                if (req_ready != '0 || rom_en) begin
                    if (gq.size() == 0) begin
                        chk("grant_unexpected", 64'({req_ready, rom_en}), 64'(0));
                    end else begin
                        g = gq.pop_front();
                        chk("grant_onehot", 64'(req_ready), 64'(1) << g.idx);
                        chk("grant_rom_en", 64'(rom_en), 64'(1));
                        chk("grant_rom_addr", 64'(rom_addr), 64'(g.addr));
                        chk("grant_cycle", 64'(cyc), 64'(g.cyc));
                    end
                    idx = -1;
                    for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
                    glog.push_back(idx);
                    gcyc.push_back(cyc);
                end
                if (rsp_valid != '0) begin
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        r = rq.pop_front();
                        chk("rsp_onehot", 64'(rsp_valid), 64'(1) << r.idx);
                        chk("rsp_data", rsp_data, r.data);
                        chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
                    end
                    if (rsp_valid[1]) rsp1_cnt++;
                end
            end
        end
    end

    // Advance one cycle; requesters drop on ready, free up on response, optionally re-request.
    task automatic tick();
        @(posedge clk_calculation);
        #2;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] === 1'b1) begin
                req_valid[i] = 1'b0;
                outst[i]     = 1'b1;
            end
            if (rsp_valid[i] === 1'b1) outst[i] = 1'b0;
            if (auto_rq[i] && !req_valid[i] && !outst[i]) begin
                req_valid[i]          = 1'b1;
                req_addr[i*AW +: AW]  = AW'($urandom);
            end
        end
    endtask

    task automatic wait_grants(int n, int base, string name);
        int t;
        t = 0;
        while (glog.size() < base + n && t < 100) begin
            tick();
            t++;
        end
        if (glog.size() < base + n) chk(name, 64'(glog.size() - base), 64'(n));
    endtask

    task automatic quiesce();
        int t;
        t = 0;
        auto_rq = '0;
        for (int i = 0; i < NR; i++) if (!outst[i]) req_valid[i] = 1'b0;
        while ((outst != '0 || busy !== 1'b0) && t < 50) begin
            tick();
            t++;
        end
        chk("quiesce_timeout", 64'(outst != '0 || busy !== 1'b0), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, t, b1, gb;
        for (int k = 0; k < 1024; k++) mem[k] = {$urandom, $urandom};
        mem[5] = 64'hA5;
        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        outst = '0;
        auto_rq = '0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", rsp_data, 64'(0));
        chk("reset_rom_en", 64'(rom_en), 64'(0));
        chk("reset_rom_addr", 64'(rom_addr), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        reset = 1'b0;

        // Single request from UI at address 5.
        base = glog.size();
        req_addr[0 +: AW] = 10'h005;
        req_valid[0] = 1'b1;
        t = 0;
        while (rsp_valid[0] !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("single_rsp_data", rsp_data, 64'hA5);
        if (glog.size() > base) chk("single_grant_idx", 64'(glog[base]), 64'(0));
        quiesce();

        // Rotation skip: after grant to 0, only 0 and 2 valid -> 2 then 0.
        base = glog.size();
        auto_rq = 3'b101;
        wait_grants(2, base, "rotate_grants");
        quiesce();
        if (glog.size() >= base + 2) begin
            chk("rotate_first", 64'(glog[base]), 64'(2));
            chk("rotate_second", 64'(glog[base+1]), 64'(0));
        end

        // Withdrawal: requester 1 pulses valid for one cycle while busy.
        b1 = rsp1_cnt;
        gb = glog.size();
        req_addr[0 +: AW] = AW'($urandom);
        req_valid[0] = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        req_addr[AW +: AW] = 10'h3c0;
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        quiesce();
        repeat (4) tick();
        chk("withdraw_no_rsp1", 64'(rsp1_cnt), 64'(b1));
        chk("withdraw_grant_count", 64'(glog.size() - gb), 64'(1));

        // Reset one cycle after rom_en abandons the read.
        req_addr[2*AW +: AW] = 10'h123;
        req_valid[2] = 1'b1;
        t = 0;
        while (rom_en !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        tick();
        reset = 1'b1;
        tick();
        chk("rst_wait_req_ready", 64'(req_ready), 64'(0));
        chk("rst_wait_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_wait_rsp_data", rsp_data, 64'(0));
        chk("rst_wait_rom_en", 64'(rom_en), 64'(0));
        chk("rst_wait_rom_addr", 64'(rom_addr), 64'(0));
        chk("rst_wait_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        outst = '0;
        req_valid = '0;

        // Round robin with everyone re-requesting: 0,1,2,0,1,2 every LAT+2 cycles.
        base = glog.size();
        auto_rq = 3'b111;
        wait_grants(6, base, "rr_grants");
        quiesce();
        for (int k = 0; k < 6; k++) begin
            if (glog.size() > base + k) begin
                chk("rr_order", 64'(glog[base+k]), 64'(k % 3));
                if (k > 0) chk("rr_period", 64'(gcyc[base+k] - gcyc[base+k-1]), 64'(LAT + 2));
            end
        end

        // Randomized traffic with withdrawals and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            tick();
            if ($urandom_range(199) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                outst = '0;
            end
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && !outst[i] && $urandom_range(3) == 0) begin
                    req_valid[i]         = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end else if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        quiesce();
        repeat (LAT + 4) tick();
        chk("grant_queue_drained", 64'(gq.size()), 64'(0));
        chk("rsp_queue_drained", 64'(rq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/runtime_rom_arbiter.md
Name: runtime_rom_arbiter

Overview:
- Shares one single-port synchronous pattern ROM among NUM_REQ runtime readers: UI runtime, attack runtime and platform runtime.
- Arbitrates with rotating (round-robin) priority and issues one ROM read per grant.
- Returns the read word to the winning requester with a one-cycle valid pulse.
- Sits between the per-subsystem ROM readers and the shared ROM, all in the clk_calculation domain.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = UI, 1 = attack, 2 = platform).
- ADDR_WIDTH, 10, ROM address width (1024 entries).
- DATA_WIDTH, 64, ROM word width.
- ROM_LATENCY, 1, cycles from rom_en sampled by the ROM to rom_data valid (must be >= 1).

Ports:
- clk_calculation  input  1  system calculation clock.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester read request; held high until req_ready is seen or the request is withdrawn.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while req_valid[i] is high.
- req_ready  output  NUM_REQ  one-hot, one-cycle grant pulse.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_data  output  DATA_WIDTH  response word; held until the next response.
- rom_en  output  1  ROM read enable, one-cycle pulse.
- rom_addr  output  ADDR_WIDTH  ROM address; held after the pulse.
- rom_data  input  DATA_WIDTH  ROM read data.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clk_calculation. All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rom_en=0, rom_addr=0, busy=0. State=IDLE, owner=0, last_grant=NUM_REQ-1 (requester 0 wins first), wait counter=0.
- FSM states: IDLE, WAIT.
- IDLE, at an edge where any req_valid is high:
  - Pick the winner: the first index with req_valid high, searching last_grant+1, last_grant+2, ..., wrapping modulo NUM_REQ.
  - Register: rom_en=1, rom_addr=req_addr[winner], req_ready=onehot(winner), owner=winner, last_grant=winner, cnt=ROM_LATENCY, state=WAIT.
- IDLE with no request: stay in IDLE; last_grant is unchanged.
- WAIT:
  - rom_en and req_ready return to 0 on the first WAIT edge.
  - cnt decrements by 1 each edge while cnt != 0.
  - At an edge where cnt == 0: rsp_data=rom_data, rsp_valid=onehot(owner) for one cycle, state=IDLE.
- req_valid is ignored in WAIT. A requester that holds req_valid during its own req_ready cycle is not re-granted.
- Timing with grant at edge E0:
  - rom_en and req_ready are high in cycle E0..E1.
  - Data is captured at edge E(ROM_LATENCY+1).
  - rsp_valid is high in the following cycle.
  - The earliest next grant is at edge E(ROM_LATENCY+2).
  - Throughput: one read per ROM_LATENCY+2 cycles.
- Withdrawal: dropping req_valid before a grant is legal; nothing is issued for that requester.
- A requester re-requests only after its rsp_valid. Back-to-back requests from one requester are permitted and alternate with other requesters under rotation.
- Starvation bound: a continuously valid requester is granted within NUM_REQ grants.
- Reset mid-WAIT: the transaction is abandoned, no rsp_valid is produced, and all state takes reset values.
- rom_addr is not cleared after the pulse; the ROM is only sensitive to rom_en.

Decomposition:
- Shared package/header: NUM_REQ, ADDR_WIDTH, DATA_WIDTH, ROM_LATENCY, requester indices REQ_UI=0, REQ_ATTACK=1, REQ_PLATFORM=2, state encodings IDLE/WAIT.
- One sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: req_valid, last_grant. Outputs: winner index, any_req.
  - Keeps the rotate/search logic separately testable.

Test Plan:
- Single request: req_valid=3'b001, addr0=10'h005, ROM returns 64'hA5 -> req_ready=001 and rom_en=1 with rom_addr=5 at E0+1; rsp_valid=001 with rsp_data=64'hA5 at E0+ROM_LATENCY+2; busy high across the transaction.
- Round-robin fairness: all three req_valid held high, re-asserted after each response -> grant order 0,1,2,0,1,2; period exactly ROM_LATENCY+2 cycles.
- Rotation skip: after a grant to 0, only requesters 0 and 2 are valid -> 2 is granted next, then 0.
- Withdrawal: req_valid[1] pulsed for one cycle while busy, then dropped -> requester 1 is never granted and rsp_valid[1] stays 0.
- Reset in WAIT: reset asserted one cycle after rom_en -> rsp_valid stays 0; outputs are zero next cycle; the next request with all valid grants requester 0.
- Latency parameter: rebuild with ROM_LATENCY=3 -> rsp_valid occurs exactly 5 cycles after the grant edge and rsp_data equals the ROM word for rom_addr.
